axi_burst_mem_slave: RTL and testbench
======================================

# axi_burst_mem_slave

Parametrised burst memory slave with independent read and write channels, in the style of a simplified AXI slave. Read and write state machines run concurrently against one simple-dual-port array. It sits behind the bus master as the next-generation addressable memory target. It adds configurable width and depth, per-beat error responses, ID echo on both channels and full valid/ready backpressure.

## Interface
- DATA_W, 8: data beat width
- ADDR_W, 8: address width, in beat-sized words
- DEPTH, 256: number of implemented words, ≤ 2^ADDR_W
- ID_W, 4: transaction ID width
- LEN_W, 4: burst length field; burst = LEN+1 beats

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- ARVALID, ARREADY  in/out  1  read address handshake
- ARADDR  in  ADDR_W  read start address
- ARLEN  in  LEN_W  read beats minus 1
- ARID  in  ID_W  read ID
- RVALID  out  1, RREADY  in  1  read data handshake
- RDATA  out  DATA_W  read beat data
- RID  out  ID_W  echoes ARID
- RRESP  out  2  00 OKAY, 10 SLVERR
- RLAST  out  1  final beat
- AWVALID, AWREADY  in/out  1  write address handshake
- AWADDR  in  ADDR_W  write start address
- AWLEN  in  LEN_W  write beats minus 1
- AWID  in  ID_W  write ID
- WVALID, WREADY  in/out  1  write data handshake
- WDATA  in  DATA_W  write beat data
- WLAST  in  1  master's last-beat marker
- BVALID  out  1, BREADY  in  1  write response handshake
- BID  out  ID_W  echoes AWID
- BRESP  out  2  00 OKAY, 10 SLVERR

## Operation
- Read FSM states:
  - R_IDLE: ARREADY=1. On ARVALID&&ARREADY, latch ARID, ARLEN and ARADDR, clear the beat counter, then go to R_DATA.
  - R_DATA: ARREADY=0 and RVALID=1. RDATA, RRESP and RLAST stay stable while RVALID && !RREADY.
  - On each RREADY beat, the address increments and the counter increments.
  - On the beat where counter==len, the state returns to R_IDLE.
- Read beat response:
  - Address < DEPTH: RDATA=mem[addr], RRESP=00.
  - Address ≥ DEPTH: RDATA=0, RRESP=10. The burst continues to completion.
- RLAST=1 only on beat index len.
- Write FSM states:
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY, latch the AW fields, clear the error flag, then go to W_DATA.
  - W_DATA: WREADY=1. On each WVALID, write WDATA to mem[addr] if addr < DEPTH. Otherwise drop the beat and set the error flag.
  - W_DATA (WLAST check): if WLAST≠(counter==len), set the error flag.
  - W_DATA (exit): after the beat where counter==len, go to W_RESP. An early WLAST does not end the burst.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=error?10:00. On BREADY, return to W_IDLE.
- Address arithmetic is ADDR_W+1 bits wide and does not wrap. A burst crossing DEPTH errors on the overflow beats only.
- The two channels are fully independent. A read and a write may be active in the same cycle.
- Same-cycle read and write to one word: the read returns the pre-write data.
- The memory array is not affected by rst.

## Timing
- In rst, all outputs are 0 and both FSMs are idle. ARREADY and AWREADY rise on the first clk edge after rst falls.
- AR handshake at edge N: ARREADY=0 and RVALID=1 with beat 0 valid from edge N. ARREADY is never high while RVALID is high.
- The next beat is presented on the edge after each accepted beat. Zero-wait throughput is 1 beat/cycle.
- After the last R beat, ARREADY=1 on the following edge, giving 1 idle cycle between read bursts.
- AW handshake at edge N: WREADY=1 from edge N. A write is committed on the same edge as its W handshake.
- After the last W beat, BVALID=1 on the next edge. After the BREADY handshake, AWREADY=1 on the next edge.
- rst asserted mid-burst aborts both FSMs immediately. Memory keeps any beats already written.

## Test plan
- Write burst AWADDR=0x10, AWLEN=3, AWID=5, WDATA 0xA1..0xA4 with WLAST on beat 3 -> BVALID with BID=5, BRESP=00. Then read ARADDR=0x10, ARLEN=3, ARID=9 -> RDATA A1,A2,A3,A4, RID=9, RRESP=00, RLAST on beat 3 only.
- Read with RREADY toggling 1,0,0,1,... -> RDATA, RRESP and RLAST held stable while stalled. No beat is lost or duplicated.
- DEPTH=250, write AWADDR=248, AWLEN=3 -> addresses 248 and 249 are written, BRESP=10. Then read ARADDR=248, ARLEN=3 -> RRESP 00,00,10,10, with RDATA=0 on the error beats.
- Write with AWLEN=2 and WLAST on beat 1 -> 3 beats are still accepted and BRESP=10.
- Concurrent operation: a read burst at 0x40 runs while a write to 0x40 is in progress. The read returns old data for any word it reads in the same cycle as that word's write. Both responses complete correctly.
- Assert rst during beat 2 of a 4-beat read and during a write -> all outputs 0 immediately. After release, a fresh AR handshake succeeds and the words written before rst read back correctly.

Source files
------------

// File: rtl/axi_burst_mem_slave.sv
// Burst memory slave with independent AXI-style read and write channels
// sharing one simple-dual-port array; out-of-range beats answer SLVERR.
module axi_burst_mem_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [ID_W-1:0]   ARID,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [ID_W-1:0]   RID,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic [ID_W-1:0]   AWID,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WLAST,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic [1:0]        dbg_rd_state,
  output logic [1:0]        dbg_wr_state
);
  // Handshakes: a transfer occurs on a rising edge where valid and ready are
  // both high; a raised valid holds its payload stable until that edge.
  localparam int AW1   = ADDR_W + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

  r_state_t r_state;
  w_state_t w_state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW1-1:0]    raddr, raddr_nxt, rd_addr, waddr;
  logic [LEN_W-1:0]  rlen, rcnt, wlen, wcnt;
  logic              rd_ok, w_ok, werr, w_beat_err, mem_we;
  logic [DATA_W-1:0] rd_word;

  assign dbg_rd_state = r_state;
  assign dbg_wr_state = w_state;

  // The read port looks one beat ahead so each beat is registered on the
  // edge that accepts the previous one; it sees pre-write contents.
  always_comb begin
    raddr_nxt  = raddr + AW1'(1);
    rd_addr    = (r_state == R_IDLE) ? {1'b0, ARADDR} : raddr_nxt;
    rd_ok      = rd_addr < AW1'(DEPTH);
    rd_word    = rd_ok ? mem[rd_addr[IDX_W-1:0]] : '0;
    w_ok       = waddr < AW1'(DEPTH);
    w_beat_err = werr | ~w_ok | (WLAST != (wcnt == wlen));
    mem_we     = (w_state == W_DATA) && WVALID && w_ok;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr[IDX_W-1:0]] <= WDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RID     <= '0;
      RRESP   <= RESP_OKAY;
      RLAST   <= 1'b0;
      raddr   <= '0;
      rlen    <= '0;
      rcnt    <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RID     <= ARID;
            rlen    <= ARLEN;
            raddr   <= {1'b0, ARADDR};
            rcnt    <= '0;
            RDATA   <= rd_word;
            RRESP   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            RLAST   <= (ARLEN == '0);
            r_state <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            rcnt <= rcnt + LEN_W'(1);
            if (rcnt == rlen) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              r_state <= R_IDLE;
            end else begin
              raddr <= raddr_nxt;
              RDATA <= rd_word;
              RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
              RLAST <= ((rcnt + LEN_W'(1)) == rlen);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // WLAST is only checked, never obeyed: the burst always runs to AWLEN+1 beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      BRESP   <= RESP_OKAY;
      waddr   <= '0;
      wlen    <= '0;
      wcnt    <= '0;
      werr    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            BID     <= AWID;
            waddr   <= {1'b0, AWADDR};
            wlen    <= AWLEN;
            wcnt    <= '0;
            werr    <= 1'b0;
            w_state <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            wcnt  <= wcnt + LEN_W'(1);
            waddr <= waddr + AW1'(1);
            werr  <= w_beat_err;
            if (wcnt == wlen) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BRESP   <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed bench for axi_burst_mem_slave: reference memory plus R/B expected
// queues, checked by negedge monitors.
module tb_axi_burst_mem_slave;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 250;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ARVALID = 1'b0, ARREADY;
  logic [ADDR_W-1:0] ARADDR = '0;
  logic [LEN_W-1:0]  ARLEN = '0;
  logic [ID_W-1:0]   ARID = '0;
  logic RVALID, RREADY, RLAST;
  logic [DATA_W-1:0] RDATA;
  logic [ID_W-1:0]   RID;
  logic [1:0]        RRESP;
  logic AWVALID = 1'b0, AWREADY;
  logic [ADDR_W-1:0] AWADDR = '0;
  logic [LEN_W-1:0]  AWLEN = '0;
  logic [ID_W-1:0]   AWID = '0;
  logic WVALID = 1'b0, WREADY, WLAST = 1'b0;
  logic [DATA_W-1:0] WDATA = '0;
  logic BVALID, BREADY = 1'b1;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic [1:0]        dbg_rd_state, dbg_wr_state;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ID_W(ID_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  logic [7:0]  ref_mem [256];
  logic [14:0] r_q [$];   // {id, last, resp, data}
  logic [5:0]  b_q [$];   // {id, resp}
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int rready_mode = 0;    // 0: always ready, 1: pattern 1,0,0

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    k = 0;
    RREADY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      RREADY = (rready_mode == 0) ? 1'b1 : (k % 3 == 0);
      k++;
    end
  end

  // R monitor: hold check while stalled, scoreboard pop on each accepted beat.
  logic [14:0] r_held;
  bit r_stalled = 0;
  always @(negedge clk) begin
    if (rst) r_stalled = 0;
    else if (RVALID) begin
      check("ar_r_exclusive", 32'(ARREADY), 32'd0);
      if (r_stalled) check("r_stable", 32'({RID, RLAST, RRESP, RDATA}), 32'(r_held));
      if (RREADY) begin
        if (r_q.size() == 0) check("r_extra_beat", 32'(r_q.size()), 32'd1);
        else check("r_beat", 32'({RID, RLAST, RRESP, RDATA}), 32'(r_q.pop_front()));
        r_stalled = 0;
      end else begin
        r_stalled = 1;
        r_held = {RID, RLAST, RRESP, RDATA};
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && BVALID && BREADY) begin
      if (b_q.size() == 0) check("b_extra_resp", 32'(b_q.size()), 32'd1);
      else check("b_resp", 32'({BID, BRESP}), 32'(b_q.pop_front()));
    end
  end

  task automatic do_read(input int addr, input int len, input logic [3:0] id);
    for (int i = 0; i <= len; i++) begin
      int a = addr + i;
      if (a < DEPTH) r_q.push_back({id, (i == len), 2'b00, ref_mem[a]});
      else           r_q.push_back({id, (i == len), 2'b10, 8'h00});
    end
    ARADDR = 8'(addr); ARLEN = 4'(len); ARID = id; ARVALID = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ARREADY) break;
    end
    check("ar_ready", 32'(ARREADY), 32'd1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    check("r_beat0_after_ar", 32'({RVALID, ARREADY}), 32'b10);
  endtask

  task automatic do_write(input int addr, input int len, input logic [3:0] id,
                          input logic [7:0] base, input int last_at, input int gap_max);
    bit err = 0;
    for (int i = 0; i <= len; i++) begin
      if (addr + i >= DEPTH) err = 1;
      if ((i == last_at) != (i == len)) err = 1;
    end
    b_q.push_back({id, err ? 2'b10 : 2'b00});
    AWADDR = 8'(addr); AWLEN = 4'(len); AWID = id; AWVALID = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (AWREADY) break;
    end
    check("aw_ready", 32'(AWREADY), 32'd1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    check("w_ready_after_aw", 32'({WREADY, AWREADY}), 32'b10);
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      WVALID = 1'b1; WDATA = 8'(int'(base) + i); WLAST = (i == last_at);
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (WREADY) break;
      end
      check("w_ready", 32'(WREADY), 32'd1);
      @(posedge clk); #1;
      WVALID = 1'b0; WLAST = 1'b0;
    end
    check("b_valid_after_last_w", 32'(BVALID), 32'd1);
    for (int i = 0; i <= len; i++)
      if (addr + i < DEPTH) ref_mem[addr + i] = 8'(int'(base) + i);
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (r_q.size() == 0 && b_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(r_q.size() + b_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, l;
    logic [7:0] b;
    #2;
    check("reset_outputs", 32'({ARREADY, RVALID, RDATA, RID, RRESP, RLAST, AWREADY, WREADY,
                                BVALID, BID, BRESP, dbg_rd_state, dbg_wr_state}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arready_low_after_release", 32'({ARREADY, AWREADY}), 32'd0);
    @(posedge clk); #1;
    check("ready_rise_first_edge", 32'({ARREADY, AWREADY}), 32'b11);

    // Basic burst with B backpressure, then readback.
    BREADY = 1'b0;
    do_write(8'h10, 3, 4'd5, 8'hA1, 3, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("b_hold", 32'({BVALID, BID, BRESP}), 32'({1'b1, 4'd5, 2'b00}));
    BREADY = 1'b1;
    @(posedge clk); #1;
    check("aw_idle_gap", 32'({AWREADY, BVALID}), 32'd0);
    @(posedge clk); #1;
    check("awready_after_b", 32'(AWREADY), 32'd1);
    drain();
    do_read(8'h10, 3, 4'd9);
    drain();

    // Stalled read.
    rready_mode = 1;
    do_read(8'h10, 3, 4'd1);
    drain();
    rready_mode = 0;

    // Burst crossing DEPTH.
    do_write(248, 3, 4'd6, 8'hB0, 3, 1);
    drain();
    do_read(248, 3, 4'd7);
    drain();

    // Early WLAST: all beats still taken, response is SLVERR.
    do_write(8'h20, 2, 4'd3, 8'h70, 1, 1);
    drain();
    do_read(8'h20, 2, 4'd2);
    drain();

    // Concurrent read trailing a write by one cycle over the same words.
    do_write(8'h40, 3, 4'd8, 8'h50, 3, 0);
    drain();
    fork
      do_write(8'h40, 3, 4'd10, 8'hE0, 3, 0);
      begin
        @(posedge clk); #1;
        do_read(8'h40, 3, 4'd11);
      end
    join
    drain();
    do_read(8'h40, 3, 4'd12);
    drain();

    // Random bursts.
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, 200);
      l = $urandom_range(0, 15);
      b = 8'($urandom_range(0, 255));
      do_write(a, l, 4'(k), b, l, 2);
      drain();
      rready_mode = k % 2;
      do_read(a, l, 4'(k + 4));
      drain();
      rready_mode = 0;
    end

    // Reset during read beat 2 and during a write.
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 2; i++) r_q.push_back({4'd3, 1'b0, 2'b00, ref_mem[16 + i]});
    ARADDR = 8'h10; ARLEN = 4'd3; ARID = 4'd3; ARVALID = 1'b1;
    AWADDR = 8'h60; AWLEN = 4'd3; AWID = 4'd2; AWVALID = 1'b1;
    @(posedge clk); #1;
    ARVALID = 1'b0; AWVALID = 1'b0;
    check("rst_test_started", 32'({RVALID, WREADY}), 32'b11);
    WVALID = 1'b1; WDATA = 8'hC0; WLAST = 1'b0;
    @(posedge clk); #1;
    WDATA = 8'hC1;
    @(posedge clk); #1;
    rst = 1'b1;
    WVALID = 1'b0;
    #1;
    check("mid_burst_reset_outputs", 32'({ARREADY, RVALID, RDATA, RID, RRESP, RLAST, AWREADY, WREADY,
                                          BVALID, BID, BRESP, dbg_rd_state, dbg_wr_state}), 32'd0);
    ref_mem[8'h60] = 8'hC0;
    ref_mem[8'h61] = 8'hC1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_mid_reset", 32'({ARREADY, AWREADY}), 32'b11);
    do_read(8'h60, 1, 4'd4);
    drain();
    do_read(8'h10, 3, 4'd5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
